// File: rtl/tl_pkg.sv
// Shared TileLink A-channel definitions.
//   - A-channel opcode constants
//   - has_data(): true for opcodes that carry data beats
//   - state_t:    beat-counter FSM states
package tl_pkg;

    localparam logic [2:0] PUT_FULL      = 3'd0;
    localparam logic [2:0] PUT_PARTIAL   = 3'd1;
    localparam logic [2:0] ARITH         = 3'd2;
    localparam logic [2:0] LOGIC         = 3'd3;
    localparam logic [2:0] GET           = 3'd4;
    localparam logic [2:0] INTENT        = 3'd5;
    localparam logic [2:0] ACQUIRE_BLOCK = 3'd6;
    localparam logic [2:0] ACQUIRE_PERM  = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // PutFull, PutPartial, Arithmetic and Logical carry data.
    function automatic logic has_data(input logic [2:0] opcode);
        return (opcode <= LOGIC);
    endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Beat counter for TileLink A-channel messages.
// Derives the beat count of a message from opcode/size on its first beat,
// tracks the remaining beats and flags the final beat.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   fire        a beat transfers this cycle
//   opcode      A opcode (only meaningful on the first beat)
//   size        log2 transfer bytes (only meaningful on the first beat)
//   last        current beat is the final beat of its message (combinational)
//   busy        a multi-beat message is in progress
module tl_beat_counter
    import tl_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int SIZE_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fire,
    input  logic [2:0]        opcode,
    input  logic [SIZE_W-1:0] size,
    output logic              last,
    output logic              busy
);

    localparam int LOG_BYTES = $clog2(DATA_W / 8);
    localparam int SIZE_MAX  = (1 << SIZE_W) - 1;
    // Enough bits to hold the largest beat count 2^(SIZE_MAX-LOG_BYTES).
    localparam int CNT_W     = (SIZE_MAX > LOG_BYTES) ? (SIZE_MAX - LOG_BYTES + 1) : 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] beats;

    // beats = max(1, 2^size / bytes_per_beat) for data-carrying opcodes.
    always_comb begin
        beats = CNT_W'(1);
        if (has_data(opcode) && (int'(size) > LOG_BYTES))
            beats = CNT_W'(1) << (int'(size) - LOG_BYTES);
    end

    always_comb begin
        last = 1'b0;
        if (state == BURST)
            last = (cnt == CNT_W'(1));
        else
            last = (beats == CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire && (beats != CNT_W'(1))) begin
                        cnt   <= beats - CNT_W'(1);
                        state <= BURST;
                        busy  <= 1'b1;
                    end
                end
                BURST: begin
                    if (fire) begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tl_a_demux.sv
// TileLink A-channel demultiplexer.
// Routes each message of one arbitrated A stream to a slave port chosen by
// address decode on the first beat; the route stays locked for the whole
// burst. Handshake is combinational (zero latency), payload is broadcast.
// Optional macro TL_A_DEMUX_DECERR_EN adds an error port at index M that
// receives unmatched messages, plus a sticky decerr_o flag.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   valid_i / ready_o                   upstream beat handshake
//   opcode_i, size_i, addr_i, data_i    upstream payload
//   valid_o / ready_i                   per-port handshake (M or M+1 ports)
//   opcode_o, size_o, addr_o, data_o    broadcast payload
//   last_o                              current beat is final beat
//   busy_o                              multi-beat burst in progress
//   decerr_o                            sticky decode error (macro only)
module tl_a_demux
    import tl_pkg::*;
#(
    parameter int                  M      = 4,
    parameter int                  ADDR_W = 32,
    parameter int                  DATA_W = 64,
    parameter int                  SIZE_W = 3,
    parameter logic [M*ADDR_W-1:0] BASE   = '0,
    parameter logic [M*ADDR_W-1:0] MASK   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [2:0]        opcode_i,
    input  logic [SIZE_W-1:0] size_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
`ifdef TL_A_DEMUX_DECERR_EN
    output logic [M:0]        valid_o,
    input  logic [M:0]        ready_i,
    output logic              decerr_o,
`else
    output logic [M-1:0]      valid_o,
    input  logic [M-1:0]      ready_i,
`endif
    output logic [2:0]        opcode_o,
    output logic [SIZE_W-1:0] size_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              busy_o
);

`ifdef TL_A_DEMUX_DECERR_EN
    localparam int NP = M + 1;
`else
    localparam int NP = M;
`endif
    localparam int SEL_W = (NP > 1) ? $clog2(NP) : 1;

    logic [SEL_W-1:0] dec;
    logic             matched;
    logic [SEL_W-1:0] sel_lock;
    logic [SEL_W-1:0] sel;
    logic             fire;
    logic             last;
    logic             busy;

    // Scan from the top down so the lowest matching index wins.
    always_comb begin
        matched = 1'b0;
`ifdef TL_A_DEMUX_DECERR_EN
        dec = SEL_W'(M);
`else
        dec = '0;
`endif
        for (int i = M - 1; i >= 0; i--) begin
            if ((addr_i & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) begin
                dec     = SEL_W'(i);
                matched = 1'b1;
            end
        end
    end

    // Mid-burst the locked route is used; addr_i is ignored.
    assign sel  = busy ? sel_lock : dec;
    assign fire = valid_i && ready_o;

    always_comb begin
        valid_o      = '0;
        valid_o[sel] = valid_i;
        ready_o      = ready_i[sel];
    end

    assign opcode_o = opcode_i;
    assign size_o   = size_i;
    assign addr_o   = addr_i;
    assign data_o   = data_i;
    assign last_o   = last;
    assign busy_o   = busy;

    tl_beat_counter #(
        .DATA_W (DATA_W),
        .SIZE_W (SIZE_W)
    ) u_beat_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .fire   (fire),
        .opcode (opcode_i),
        .size   (size_i),
        .last   (last),
        .busy   (busy)
    );

    // Latch the route on the first beat of a multi-beat message.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sel_lock <= '0;
        else if (fire && !busy && !last)
            sel_lock <= dec;
    end

`ifdef TL_A_DEMUX_DECERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            decerr_o <= 1'b0;
        else if (fire && !busy && !matched)
            decerr_o <= 1'b1;
    end
`else
    // Unmatched addresses simply fall through to port 0.
    logic unused_matched;
    assign unused_matched = matched;
`endif

endmodule

// File: tb/tb_tl_a_demux.sv
// Self-checking bench for tl_a_demux (M=4, DATA_W=64, 4 KiB windows at
// 0x0000/0x1000/0x2000/0x3000). Directed scenarios followed by random traffic,
// all checked against a message-level reference model.
module tb_tl_a_demux;

    localparam int M      = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int SIZE_W = 3;
    localparam logic [M*ADDR_W-1:0] BASE_P = {32'h3000, 32'h2000, 32'h1000, 32'h0000};
    localparam logic [M*ADDR_W-1:0] MASK_P = {4{32'h0000_F000}};
`ifdef TL_A_DEMUX_DECERR_EN
    localparam int NP = M + 1;
`else
    localparam int NP = M;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              valid_i;
    logic              ready_o;
    logic [2:0]        opcode_i;
    logic [SIZE_W-1:0] size_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] data_i;
    logic [NP-1:0]     valid_o;
    logic [NP-1:0]     ready_i;
    logic [2:0]        opcode_o;
    logic [SIZE_W-1:0] size_o;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] data_o;
    logic              last_o;
    logic              busy_o;
`ifdef TL_A_DEMUX_DECERR_EN
    logic              decerr_o;
`endif

    always #5 clk = ~clk;

    tl_a_demux #(
        .M      (M),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SIZE_W (SIZE_W),
        .BASE   (BASE_P),
        .MASK   (MASK_P)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .opcode_i (opcode_i),
        .size_i   (size_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
`ifdef TL_A_DEMUX_DECERR_EN
        .decerr_o (decerr_o),
`endif
        .opcode_o (opcode_o),
        .size_o   (size_o),
        .addr_o   (addr_o),
        .data_o   (data_o),
        .last_o   (last_o),
        .busy_o   (busy_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: beats still owed by the message in flight
    // (0 = between messages), the port it is locked to, sticky error flag.
    int remaining = 0;
    int lock_port = 0;
    bit derr      = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Window number is address bits [15:12]; windows 0..3 are mapped.
    function automatic int ref_port(input logic [31:0] a);
        int nib;
        nib = int'(a[15:12]);
        if (nib < 4) return nib;
`ifdef TL_A_DEMUX_DECERR_EN
        return 4;
`else
        return 0;
`endif
    endfunction

    function automatic int ref_beats(input int op, input int sz);
        int bytes;
        bytes = 1 << sz;
        if (op >= 4) return 1;
        if (bytes <= DATA_W / 8) return 1;
        return bytes / (DATA_W / 8);
    endfunction

    // One clock of stimulus: drive after the edge, check mid-cycle, then
    // advance the model according to whether the beat transfers.
    task automatic cycle(input bit v, input int op, input int sz,
                         input logic [31:0] ad, input logic [NP-1:0] rdy);
        int            port;
        bit            exp_last;
        logic [NP-1:0] exp_valid;
        int            b;
        @(posedge clk);
        #1;
        valid_i  = v;
        opcode_i = 3'(op);
        size_i   = SIZE_W'(sz);
        addr_i   = ad;
        ready_i  = rdy;
        data_i   = {$urandom, $urandom};
        #3;
        port      = (remaining > 0) ? lock_port : ref_port(ad);
        exp_last  = (remaining > 0) ? (remaining == 1) : (ref_beats(op, sz) == 1);
        exp_valid = '0;
        if (v) exp_valid[port] = 1'b1;
        chk("valid_o", 64'(valid_o), 64'(exp_valid));
        chk("ready_o", 64'(ready_o), 64'(rdy[port]));
        chk("last_o",  64'(last_o),  64'(exp_last));
        chk("busy_o",  64'(busy_o),  64'(remaining > 0));
        chk("data_o",  data_o, data_i);
        chk("addr_o",  64'(addr_o), 64'(ad));
`ifdef TL_A_DEMUX_DECERR_EN
        chk("decerr_o", 64'(decerr_o), 64'(derr));
`endif
        if (v && rdy[port]) begin
            if (remaining == 0) begin
                if (ref_port(ad) == M && NP > M) derr = 1'b1;
                b = ref_beats(op, sz);
                if (b > 1) begin
                    remaining = b - 1;
                    lock_port = port;
                end
            end else begin
                remaining--;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4, 0, 32'h0, '1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("rst_busy",  64'(busy_o),  64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        remaining = 0;
        derr      = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NP-1:0] stall;
        logic [31:0]   ad;
        int            op, sz;
        bit            v;

        rst_n    = 1'b0;
        valid_i  = 1'b0;
        opcode_i = 3'd4;
        size_i   = '0;
        addr_i   = '0;
        data_i   = '0;
        ready_i  = '1;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_busy",  64'(busy_o),  64'd0);
        chk("reset_valid", 64'(valid_o), 64'd0);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Single-beat Get to port 1.
        cycle(1'b1, 4, 3, 32'h1008, '1);
        idle(1);

        // 4-beat PutFull locked to port 2 while the address wanders.
        cycle(1'b1, 0, 5, 32'h2000, '1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 0, 5, 32'h0000, '1);
        idle(1);

        // Same burst with port 2 stalled for 3 cycles after beat 2,
        // followed back-to-back by a Get to port 1.
        stall    = '1;
        stall[2] = 1'b0;
        cycle(1'b1, 0, 5, 32'h2000, '1);
        cycle(1'b1, 0, 5, 32'h0000, '1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 0, 5, 32'h0000, stall);
        cycle(1'b1, 0, 5, 32'h0000, '1);
        cycle(1'b1, 0, 5, 32'h0000, '1);
        cycle(1'b1, 4, 3, 32'h1000, '1);
        idle(1);

        // Reset in the middle of a burst, then a Get to port 3.
        cycle(1'b1, 0, 5, 32'h2000, '1);
        cycle(1'b1, 0, 5, 32'h0000, '1);
        pulse_reset();
        cycle(1'b1, 4, 3, 32'h3000, '1);
        idle(1);

        // Unmatched address.
        cycle(1'b1, 4, 3, 32'h9000, '1);
        idle(2);

        // Longest burst (16 beats) on port 3.
        cycle(1'b1, 1, 7, 32'h3040, '1);
        for (int i = 0; i < 15; i++) cycle(1'b1, 1, 7, 32'h9000, '1);
        idle(1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            v  = ($urandom_range(0, 9) < 8);
            op = $urandom_range(0, 7);
            sz = $urandom_range(0, 7);
            ad = $urandom;
            if ($urandom_range(0, 3) != 0) ad[15:12] = 4'($urandom_range(0, 3));
            cycle(v, op, sz, ad, NP'($urandom));
            if (i == 1500) pulse_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
